// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART frame constants and receiver state encoding
package uart_rx_pkg;
    localparam int DEF_DIV_WID = 10;
    localparam logic [DEF_DIV_WID-1:0] DEF_DIV_CNT = 10'd520;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, read strobe and received-byte status between host logic and receiver
interface uart_rx_if;
    import uart_rx_pkg::*;
    logic                 uart_mosi;
    logic                 rden;
    logic [DATA_BITS-1:0] data;
    logic                 rxvalid;
    logic                 frm_err;
    logic                 overrun;
    logic                 busy;
    modport master (output uart_mosi, rden, input data, rxvalid, frm_err, overrun, busy);
    modport slave (input uart_mosi, rden, output data, rxvalid, frm_err, overrun, busy);
endinterface

// File: rtl/uart_rx_sync2.sv
// uart_rx_sync2: two-flop synchroniser for an asynchronous input with a chosen reset level
module uart_rx_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    // shift the pin through two flops so q is safe to use in the clk domain
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= {RST_VAL, RST_VAL};
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling at bit centres, holding each byte with framing-error and overrun flags
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV_WID = DEF_DIV_WID,
    parameter logic [DIV_WID-1:0] DIV_CNT = DEF_DIV_CNT
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [DIV_WID-1:0] HALF = DIV_CNT >> 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    logic                 rx_s;
    state_t               state, state_n;
    logic [DIV_WID-1:0]   div, div_n;
    logic [BW-1:0]        bitcnt, bitcnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 tick;
    logic                 dlv, dlv_n;
    logic                 stop;
    logic [DATA_BITS-1:0] data_q;
    logic                 rxvalid_q, frm_err_q, overrun_q;
    uart_rx_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (bus.uart_mosi),
        .q  (rx_s)
    );
    assign tick = div == '0;
    // frame sequencing: start-bit qualification, data shifting, stop check, break wait
    always_comb begin
        state_n  = state;
        div_n    = div;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        dlv_n    = 1'b0;
        unique case (state)
            IDLE: if (!rx_s) begin
                state_n = START;
                div_n   = HALF;
            end
            START: if (tick) begin
                state_n  = rx_s ? IDLE : DATA;
                div_n    = rx_s ? '0 : DIV_CNT;
                bitcnt_n = '0;
            end else div_n = div - DIV_WID'(1);
            DATA: if (tick) begin
                shift_n  = {rx_s, shift[DATA_BITS-1:1]};
                bitcnt_n = bitcnt + BW'(1);
                div_n    = DIV_CNT;
                state_n  = bitcnt == LAST_BIT ? STOP : DATA;
            end else div_n = div - DIV_WID'(1);
            STOP: if (tick) begin
                dlv_n   = 1'b1;
                div_n   = '0;
                state_n = rx_s ? IDLE : BREAK;
            end else div_n = div - DIV_WID'(1);
            BREAK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // state register; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // prescaler, bit counter, shift register and one-cycle deliver strobe
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            div    <= '0;
            bitcnt <= '0;
            shift  <= '0;
            dlv    <= 1'b0;
            stop   <= 1'b1;
        end else begin
            div    <= div_n;
            bitcnt <= bitcnt_n;
            shift  <= shift_n;
            dlv    <= dlv_n;
            if (dlv_n) stop <= rx_s;
        end
    // output holding registers; a delivery takes priority over a read in the same cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            data_q    <= '0;
            rxvalid_q <= 1'b0;
            frm_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (dlv) begin
            data_q    <= shift;
            frm_err_q <= ~stop;
            rxvalid_q <= 1'b1;
            overrun_q <= overrun_q | (rxvalid_q & ~bus.rden);
        end else if (bus.rden && rxvalid_q) begin
            rxvalid_q <= 1'b0;
            overrun_q <= 1'b0;
        end
    assign bus.data    = data_q;
    assign bus.rxvalid = rxvalid_q;
    assign bus.frm_err = frm_err_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = state != IDLE;
endmodule
